// File: rtl/multicycle_core.sv
// Multicycle processor core: control FSM, register file, ALU and condition logic
// sharing one req/ready memory port for instruction fetch and data accesses.
module multicycle_core #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       NREGS    = 15
) (
   input  logic              CLK,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_o,
   output logic [2:0]        state_o,
   output logic [3:0]        ALUFlags,
   output logic              retire
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   logic [2:0]        state, state_nx;
   logic [ADDR_W-1:0] pc, pc_plus4, btarget, boff, maddr;
   logic [31:0]       ir;
   logic [3:0]        flags;
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] ldata;

   logic [3:0]        cond, cmd, rn, rd, rm;
   logic [1:0]        op;
   logic              immf, sbit, up, ld;
   logic              fn, fz, fc, fv, cond_ok;
   logic [DATA_W-1:0] r15_val, rn_val, rm_val, rd_val, srcb, offs, ea;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_v, dp_valid;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic signed [25:0] boff26;

   assign cond = ir[31:28];
   assign op   = ir[27:26];
   assign immf = ir[25];
   assign cmd  = ir[24:21];
   assign up   = ir[23];
   assign sbit = ir[20];
   assign ld   = ir[20];
   assign rn   = ir[19:16];
   assign rd   = ir[15:12];
   assign rm   = ir[3:0];
   assign {fn, fz, fc, fv} = flags;

   assign pc_plus4 = pc + ADDR_W'(4);

   // R15 reads as the already-incremented pc plus 4, i.e. instruction address + 8.
   always_comb begin
      r15_val = '0;
      r15_val[ADDR_W-1:0] = pc_plus4;
   end

   always_comb begin
      rn_val = (rn == 4'hF) ? r15_val : '0;
      rm_val = (rm == 4'hF) ? r15_val : '0;
      rd_val = (rd == 4'hF) ? r15_val : '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (32'(rn) == i) rn_val = regs[i];
         if (32'(rm) == i) rm_val = regs[i];
         if (32'(rd) == i) rd_val = regs[i];
      end
   end

   always_comb begin
      case (cond)
         4'h0:    cond_ok = fz;
         4'h1:    cond_ok = !fz;
         4'h2:    cond_ok = fc;
         4'h3:    cond_ok = !fc;
         4'h4:    cond_ok = fn;
         4'h5:    cond_ok = !fn;
         4'h6:    cond_ok = fv;
         4'h7:    cond_ok = !fv;
         4'h8:    cond_ok = fc && !fz;
         4'h9:    cond_ok = !fc || fz;
         4'hA:    cond_ok = (fn == fv);
         4'hB:    cond_ok = (fn != fv);
         4'hC:    cond_ok = !fz && (fn == fv);
         4'hD:    cond_ok = fz || (fn != fv);
         4'hE:    cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   assign srcb = immf ? DATA_W'(ir[7:0]) : rm_val;

   always_comb begin
      sum      = '0;
      alu_res  = '0;
      alu_c    = fc;
      alu_v    = fv;
      dp_valid = 1'b1;
      case (cmd)
         CMD_ADD: begin
            sum     = {1'b0, rn_val} + {1'b0, srcb};
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_v   = (rn_val[DATA_W-1] == srcb[DATA_W-1]) && (alu_res[DATA_W-1] != rn_val[DATA_W-1]);
         end
         CMD_SUB: begin
            sum     = {1'b0, rn_val} + {1'b0, ~srcb} + {{DATA_W{1'b0}}, 1'b1};
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_v   = (rn_val[DATA_W-1] != srcb[DATA_W-1]) && (alu_res[DATA_W-1] != rn_val[DATA_W-1]);
         end
         CMD_AND: alu_res = rn_val & srcb;
         CMD_ORR: alu_res = rn_val | srcb;
         default: dp_valid = 1'b0;
      endcase
   end

   assign offs  = DATA_W'(ir[11:0]);
   assign ea    = up ? (rn_val + offs) : (rn_val - offs);
   assign maddr = ea[ADDR_W-1:0];

   assign boff26  = {ir[23:0], 2'b00};
   assign boff    = ADDR_W'(boff26);
   assign btarget = pc_plus4 + boff;

   assign mem_req   = (state == S_FETCH) || (state == S_MEM);
   assign mem_we    = (state == S_MEM) && !ld;
   assign mem_addr  = (state == S_MEM) ? maddr : pc;
   assign mem_wdata = ((state == S_MEM) && !ld) ? rd_val : '0;
   assign pc_o      = pc;
   assign state_o   = state;
   assign ALUFlags  = flags;

   always_comb begin
      state_nx = S_FETCH;
      retire   = 1'b0;
      wr_en    = 1'b0;
      wr_data  = alu_res;
      case (state)
         S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            state_nx = cond_ok ? S_EXEC : S_FETCH;
            retire   = !cond_ok;
         end
         S_EXEC: begin
            state_nx = (op == 2'b01) ? S_MEM : S_FETCH;
            retire   = (op != 2'b01);
            wr_en    = (op == 2'b00) && dp_valid;
         end
         S_MEM: begin
            state_nx = !mem_ready ? S_MEM : (ld ? S_WB : S_FETCH);
            retire   = mem_ready && !ld;
         end
         S_WB: begin
            retire  = 1'b1;
            wr_en   = 1'b1;
            wr_data = ldata;
         end
         default: state_nx = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
         flags <= '0;
         ldata <= '0;
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         state <= state_nx;
         if ((state == S_FETCH) && mem_ready) begin
            ir <= mem_rdata[31:0];
            pc <= pc_plus4;
         end
         if ((state == S_EXEC) && (op == 2'b10)) pc <= btarget;
         if ((state == S_EXEC) && (op == 2'b00) && dp_valid && sbit)
            flags <= {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
         if ((state == S_MEM) && ld && mem_ready) ldata <= mem_rdata;
         // Rd=15 never matches an index below NREGS, so pc writes are skipped here.
         for (int unsigned i = 0; i < NREGS; i++)
            if (wr_en && (32'(rd) == i)) regs[i] <= wr_data;
      end
   end

endmodule
